// File: rtl/ml_kem_byte_encode.sv
// ByteEncode_D: packs 256 D-bit coefficients LSB-first into a little-endian stream of 64-bit words.
// A 75-bit accumulator absorbs one coefficient per cycle and releases a word once 64 bits are present.
module ml_kem_byte_encode #(
  parameter int D      = 12,
  parameter int N_COEF = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [11:0] coef_i,
  input  logic        coef_valid_i,
  output logic        coef_ready_o,
  output logic [63:0] word_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        word_last_o,
  output logic        busy_o,
  output logic        done_o
);
  localparam logic [5:0] LAST_WORD = 6'(4 * D - 1);
  localparam logic [8:0] LAST_COEF = 9'(N_COEF - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [74:0] acc_reg, acc_next;
  logic [6:0]  fill_reg, fill_next;
  logic [8:0]  coef_cnt_reg, coef_cnt_next;
  logic [5:0]  word_cnt_reg, word_cnt_next;
  logic        done_reg, done_next;

  logic        coef_hs, word_hs;
  logic [74:0] acc_shift, coef_ext;
  logic [6:0]  fill_base;

  assign word_valid_o = (fill_reg >= 7'd64);
  assign coef_ready_o = (state_reg == RUN) && (fill_reg < 7'd64);
  assign word_o       = acc_reg[63:0];
  assign word_last_o  = word_valid_o && (word_cnt_reg == LAST_WORD);
  assign busy_o       = (state_reg != IDLE);
  assign done_o       = done_reg;

  assign coef_hs = coef_valid_i && coef_ready_o;
  assign word_hs = word_valid_o && word_ready_i;

  // A word leaving this cycle frees the low 64 bits before the new coefficient lands.
  assign acc_shift = word_hs ? {64'd0, acc_reg[74:64]} : acc_reg;
  assign fill_base = word_hs ? (fill_reg - 7'd64) : fill_reg;
  assign coef_ext  = 75'(coef_i[D-1:0]) << fill_base;

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    fill_next     = fill_reg;
    coef_cnt_next = coef_cnt_reg;
    word_cnt_next = word_cnt_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next    = RUN;
          acc_next      = '0;
          fill_next     = '0;
          coef_cnt_next = '0;
          word_cnt_next = '0;
        end
      end
      default: begin
        acc_next  = coef_hs ? (acc_shift | coef_ext) : acc_shift;
        fill_next = fill_base + (coef_hs ? 7'(D) : 7'd0);
        if (coef_hs) begin
          coef_cnt_next = coef_cnt_reg + 9'd1;
        end
        if (word_hs) begin
          word_cnt_next = (word_cnt_reg == LAST_WORD) ? 6'd0 : word_cnt_reg + 6'd1;
        end
        if ((state_reg == RUN) && coef_hs && (coef_cnt_reg == LAST_COEF)) begin
          state_next = DRAIN;
        end
        // 256*D is a whole number of words, so the final word always leaves from DRAIN.
        if ((state_reg == DRAIN) && word_hs && (word_cnt_reg == LAST_WORD)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      fill_reg     <= '0;
      coef_cnt_reg <= '0;
      word_cnt_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      fill_reg     <= fill_next;
      coef_cnt_reg <= coef_cnt_next;
      word_cnt_reg <= word_cnt_next;
      done_reg     <= done_next;
    end
  end

endmodule

// File: tb/tb_ml_kem_byte_encode.sv
// Bench for ml_kem_byte_encode: three instances (D=12, D=1, D=10) share stimulus;
// each scenario resets, encodes one polynomial on one instance and checks its words.
module tb_ml_kem_byte_encode;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] coef;
  logic        coef_valid;
  logic        word_ready;

  logic [2:0][63:0] word_w;
  logic [2:0]       coef_ready, word_valid, word_last, busy, done;

  logic [11:0] coefs [256];
  logic [63:0] got_w [48];
  int          got_n, last_cnt, last_pos, done_cnt, done_ok, stall_err, stall_samples, max_fill;
  bit          timed_out;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ml_kem_byte_encode #(.D(12)) dut12 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .coef_i(coef), .coef_valid_i(coef_valid),
    .coef_ready_o(coef_ready[0]), .word_o(word_w[0]), .word_valid_o(word_valid[0]),
    .word_ready_i(word_ready), .word_last_o(word_last[0]), .busy_o(busy[0]), .done_o(done[0])
  );
  ml_kem_byte_encode #(.D(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .coef_i(coef), .coef_valid_i(coef_valid),
    .coef_ready_o(coef_ready[1]), .word_o(word_w[1]), .word_valid_o(word_valid[1]),
    .word_ready_i(word_ready), .word_last_o(word_last[1]), .busy_o(busy[1]), .done_o(done[1])
  );
  ml_kem_byte_encode #(.D(10)) dut10 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .coef_i(coef), .coef_valid_i(coef_valid),
    .coef_ready_o(coef_ready[2]), .word_o(word_w[2]), .word_valid_o(word_valid[2]),
    .word_ready_i(word_ready), .word_last_o(word_last[2]), .busy_o(busy[2]), .done_o(done[2])
  );

  function automatic int fill_of(input int sel);
    case (sel)
      0:       return int'(dut12.fill_reg);
      1:       return int'(dut1.fill_reg);
      default: return int'(dut10.fill_reg);
    endcase
  endfunction

  // Reference ByteEncode: stream bit b belongs to coefficient b/D, bit b%D.
  function automatic logic [63:0] ref_word(input int dval, input int k);
    logic [63:0] w;
    logic [11:0] c;
    w = '0;
    for (int b = 0; b < 64; b++) begin
      c = coefs[(64 * k + b) / dval];
      w[b] = c[(64 * k + b) % dval];
    end
    return w;
  endfunction

  function automatic int count_mismatch(input int dval, input int nwords);
    int m;
    m = 0;
    for (int k = 0; k < nwords; k++) begin
      if (got_w[k] !== ref_word(dval, k)) m++;
    end
    return m;
  endfunction

  task automatic random_coefs();
    for (int i = 0; i < 256; i++) coefs[i] = 12'($urandom_range(4095, 0));
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drives one polynomial into instance sel and records every output word and status event.
  task automatic run_poly(input int sel, input int dval, input bit rnd, input int stall_word,
                          input int stop_at, input bit poke);
    int ci, extra, stall_left, f;
    bit c_hs, w_hs, prev_last_hs, held_ok, stalled, poked_run, poked_drain;
    logic [63:0] held;
    ci = 0; extra = 0; stall_left = 0; held = '0;
    prev_last_hs = 0; held_ok = 0; stalled = 0; poked_run = 0; poked_drain = 0;
    got_n = 0; last_cnt = 0; last_pos = -1; done_cnt = 0; done_ok = 0;
    stall_err = 0; stall_samples = 0; max_fill = 0; timed_out = 1;
    @(posedge clk); #1;
    start = 1'b1; coef = coefs[0]; coef_valid = 1'b1; word_ready = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      c_hs = coef_valid && coef_ready[sel];
      w_hs = word_valid[sel] && word_ready;
      f = fill_of(sel);
      if (f > max_fill) max_fill = f;
      if (done[sel]) begin
        done_cnt++;
        if (prev_last_hs) done_ok++;
      end
      prev_last_hs = w_hs && word_last[sel];
      if (stall_left > 0 && word_valid[sel]) begin
        stall_samples++;
        if (!held_ok) begin
          held = word_w[sel];
          held_ok = 1;
        end else if (word_w[sel] !== held) stall_err++;
        if (coef_ready[sel] !== 1'b0) stall_err++;
      end
      if (w_hs) begin
        $display("tb: D=%0d word %0d = %016h last=%0b", dval, got_n, word_w[sel], word_last[sel]);
        if (got_n < 48) got_w[got_n] = word_w[sel];
        if (word_last[sel]) begin
          last_cnt++;
          last_pos = got_n;
        end
        got_n++;
      end
      if (done_cnt > 0) begin
        extra++;
        if (extra > 3) begin
          timed_out = 0;
          break;
        end
      end
      @(posedge clk); #1;
      if (c_hs) ci++;
      if (stop_at > 0 && ci >= stop_at) begin
        timed_out = 0;
        break;
      end
      start = 1'b0;
      if (poke && !poked_run && ci == 50) begin
        start = 1'b1;
        poked_run = 1;
      end
      if (poke && !poked_drain && ci == 256) begin
        start = 1'b1;
        poked_drain = 1;
      end
      if (ci < 256) begin
        coef = coefs[ci];
        coef_valid = !rnd || ($urandom_range(1, 0) == 1);
      end else begin
        coef = 12'h000;
        coef_valid = 1'b0;
      end
      if (stall_left > 0) stall_left--;
      if (stall_word > 0 && !stalled && got_n == stall_word) begin
        stalled = 1;
        stall_left = 20;
      end
      word_ready = (stall_left == 0) && (!rnd || ($urandom_range(1, 0) == 1));
    end
    start = 1'b0; coef_valid = 1'b0; word_ready = 1'b1;
  endtask

  task automatic test_reset();
    int viol;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({word_w, word_valid, word_last, coef_ready, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h required=0", {word_w, word_valid, word_last, coef_ready, busy, done});
    end
    @(posedge clk); #3 rst = 1'b0;
    coef = 12'h123; coef_valid = 1'b1;
    viol = 0;
    repeat (8) begin
      @(negedge clk);
      if ((coef_ready | busy | word_valid | done) !== 3'b000) viol++;
    end
    coef_valid = 1'b0;
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL idle_no_accept violations=%0d required=0", viol);
    end
  endtask

  task automatic test_basic_d12();
    logic [11:0] head [11];
    int mism;
    head = '{12'haab, 12'h8b5, 12'hb49, 12'h7d3, 12'h37a, 12'h5a5,
             12'h2d9, 12'h83f, 12'hb73, 12'h22b, 12'hcdc};
    random_coefs();
    for (int i = 0; i < 11; i++) coefs[i] = head[i];
    do_reset();
    run_poly(0, 12, 0, 0, 0, 0);
    checks++;
    if (timed_out !== 1'b0 || got_n !== 48) begin
      errors++;
      $display("FAIL d12_word_count got=%0d timeout=%0b required=48", got_n, timed_out);
    end
    checks++;
    if (got_w[0] !== 64'h537a7d3b498b5aab) begin
      errors++;
      $display("FAIL d12_word0 got=%016h required=537a7d3b498b5aab", got_w[0]);
    end
    checks++;
    if (got_w[1] !== 64'hdc22bb7383f2d95a) begin
      errors++;
      $display("FAIL d12_word1 got=%016h required=dc22bb7383f2d95a", got_w[1]);
    end
    mism = count_mismatch(12, 48);
    checks++;
    if (mism !== 0) begin
      errors++;
      $display("FAIL d12_all_words mismatches=%0d required=0", mism);
    end
    checks++;
    if (last_cnt !== 1 || last_pos !== 47) begin
      errors++;
      $display("FAIL d12_last count=%0d pos=%0d required count=1 pos=47", last_cnt, last_pos);
    end
    checks++;
    if (done_cnt !== 1 || done_ok !== 1) begin
      errors++;
      $display("FAIL d12_done pulses=%0d aligned=%0d required 1/1", done_cnt, done_ok);
    end
  endtask

  task automatic test_d1_masking();
    for (int i = 0; i < 256; i++) coefs[i] = (i % 2 == 0) ? 12'hfff : 12'h000;
    do_reset();
    run_poly(1, 1, 0, 0, 0, 0);
    checks++;
    if (got_n !== 4 || last_pos !== 3 || done_cnt !== 1) begin
      errors++;
      $display("FAIL d1_framing words=%0d last=%0d done=%0d required 4/3/1", got_n, last_pos, done_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_w[k] !== 64'h5555555555555555) begin
        errors++;
        $display("FAIL d1_word%0d got=%016h required=5555555555555555", k, got_w[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int mism;
    random_coefs();
    do_reset();
    run_poly(0, 12, 0, 10, 0, 0);
    checks++;
    if (stall_err !== 0 || stall_samples < 10) begin
      errors++;
      $display("FAIL stall_hold errors=%0d samples=%0d required 0 errors, >=10 samples", stall_err, stall_samples);
    end
    mism = count_mismatch(12, 48);
    checks++;
    if (got_n !== 48 || mism !== 0) begin
      errors++;
      $display("FAIL stall_words count=%0d mismatches=%0d required 48/0", got_n, mism);
    end
  endtask

  task automatic test_random_d10();
    int mism;
    random_coefs();
    do_reset();
    run_poly(2, 10, 1, 0, 0, 0);
    mism = count_mismatch(10, 40);
    checks++;
    if (got_n !== 40 || mism !== 0 || last_pos !== 39) begin
      errors++;
      $display("FAIL d10_words count=%0d mismatches=%0d last=%0d required 40/0/39", got_n, mism, last_pos);
    end
    checks++;
    if (max_fill < 64 || max_fill > 75) begin
      errors++;
      $display("FAIL d10_fill_bound max=%0d required 64..75", max_fill);
    end
    checks++;
    if (done_cnt !== 1 || done_ok !== 1) begin
      errors++;
      $display("FAIL d10_done pulses=%0d aligned=%0d required 1/1", done_cnt, done_ok);
    end
  endtask

  task automatic test_abort();
    int viol, mism;
    random_coefs();
    do_reset();
    run_poly(0, 12, 0, 0, 100, 0);
    #2 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({word_w[0], word_valid[0], word_last[0], coef_ready[0], busy[0], done[0]} !== '0) begin
      errors++;
      $display("FAIL abort_reset_outputs got=%h required=0",
               {word_w[0], word_valid[0], word_last[0], coef_ready[0], busy[0], done[0]});
    end
    @(posedge clk); #3 rst = 1'b0;
    viol = 0;
    repeat (6) begin
      @(negedge clk);
      if ({word_valid[0], busy[0], done[0], coef_ready[0]} !== 4'b0000) viol++;
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL abort_quiet violations=%0d required=0", viol);
    end
    run_poly(0, 12, 0, 0, 0, 0);
    mism = count_mismatch(12, 48);
    checks++;
    if (got_n !== 48 || mism !== 0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL abort_second_poly count=%0d mismatches=%0d done=%0d required 48/0/1", got_n, mism, done_cnt);
    end
  endtask

  task automatic test_start_ignored();
    int mism;
    random_coefs();
    do_reset();
    run_poly(0, 12, 0, 0, 0, 1);
    mism = count_mismatch(12, 48);
    checks++;
    if (got_n !== 48 || mism !== 0) begin
      errors++;
      $display("FAIL start_poke_words count=%0d mismatches=%0d required 48/0", got_n, mism);
    end
    @(negedge clk);
    checks++;
    if (done_cnt !== 1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_poke_done done=%0d busy=%0b required 1/0", done_cnt, busy[0]);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; coef = 12'h000; coef_valid = 1'b0; word_ready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic_d12();
    test_d1_masking();
    test_backpressure();
    test_random_d10();
    test_abort();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
